// File: rtl/mac_feeder.sv
// mac_feeder: sequences a K x K valid convolution over an IMG_H x IMG_W
// feature map. It issues one image/weight read per cycle, forwards the
// returned samples to a MAC together with window framing flags, and counts
// MAC results until every output pixel has been produced.

`ifndef WD
`define WD 8
`endif

module mac_feeder #(
  parameter int WD    = `WD,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int K     = 5,
  parameter int AW    = 10,
  localparam int OH   = IMG_H - K + 1,
  localparam int OW   = IMG_W - K + 1,
  localparam int WW   = (K * K > 1) ? $clog2(K * K) : 1,
  localparam int RW   = (OH * OW > 1) ? $clog2(OH * OW) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          img_rd,
  output logic [AW-1:0] img_addr,
  input  logic [WD-1:0] img_data,
  output logic          wgt_rd,
  output logic [WW-1:0] wgt_addr,
  input  logic [WD-1:0] wgt_data,
  output logic          en,
  output logic          first_data,
  output logic          last_data,
  output logic [WD-1:0] image_o,
  output logic [WD-1:0] weight_o,
  input  logic          q_en,
  output logic [RW-1:0] res_idx
);

  localparam int KW = $clog2(K + 1);

  localparam logic [AW-1:0] OROW_LAST = AW'(OH - 1);
  localparam logic [AW-1:0] OCOL_LAST = AW'(OW - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(K - 1);
  localparam logic [RW-1:0] RES_LAST  = RW'(OH * OW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] orow_q, orow_d, ocol_q, ocol_d;
  logic [KW-1:0] kr_q, kr_d, kc_q, kc_d;
  logic [RW-1:0] res_idx_q, res_idx_d;
  logic          img_rd_q, img_rd_d;
  logic [AW-1:0] img_addr_q, img_addr_d;
  logic [WW-1:0] wgt_addr_q, wgt_addr_d;
  logic          en_q, en_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic tap_first, tap_last, win_last;

  // Image address of tap (kr,kc) of the window anchored at output (r,c).
  function automatic logic [AW-1:0] img_addr_of(input logic [AW-1:0] r,
                                                input logic [AW-1:0] c,
                                                input logic [KW-1:0] tr,
                                                input logic [KW-1:0] tc);
    return (r + AW'(tr)) * AW'(IMG_W) + c + AW'(tc);
  endfunction

  function automatic logic [WW-1:0] wgt_addr_of(input logic [KW-1:0] tr,
                                                input logic [KW-1:0] tc);
    return WW'(tr) * WW'(K) + WW'(tc);
  endfunction

  // Position of the tap currently being issued within its window / the map.
  always_comb begin
    tap_first = (kr_q == '0) && (kc_q == '0);
    tap_last  = (kr_q == K_LAST) && (kc_q == K_LAST);
    win_last  = (orow_q == OROW_LAST) && (ocol_q == OCOL_LAST);
  end

  // Next-state logic: loop counters, read issue, flag pipeline, result count.
  always_comb begin
    // NOTE: every signal gets a default here so no path can leave it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    orow_d     = orow_q;
    ocol_d     = ocol_q;
    kr_d       = kr_q;
    kc_d       = kc_q;
    img_rd_d   = img_rd_q;
    img_addr_d = img_addr_q;
    wgt_addr_d = wgt_addr_q;
    done_d     = 1'b0;
    res_idx_d  = res_idx_q;

    // Flags follow the read they describe by one cycle, lining up with data.
    en_d    = img_rd_q;
    first_d = img_rd_q && tap_first;
    last_d  = img_rd_q && tap_last;

    // Results are counted independently of issue; ignored while idle.
    if (state_q != IDLE && q_en) begin
      res_idx_d = res_idx_q + RW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FETCH;
          orow_d     = '0;
          ocol_d     = '0;
          kr_d       = '0;
          kc_d       = '0;
          img_rd_d   = 1'b1;
          img_addr_d = '0;
          wgt_addr_d = '0;
          res_idx_d  = '0;
        end
      end
      FETCH: begin
        if (win_last && tap_last) begin
          state_d    = DRAIN;
          img_rd_d   = 1'b0;
          img_addr_d = '0;
          wgt_addr_d = '0;
        end else begin
          if (kc_q != K_LAST) begin
            kc_d = kc_q + KW'(1);
          end else begin
            kc_d = '0;
            if (kr_q != K_LAST) begin
              kr_d = kr_q + KW'(1);
            end else begin
              kr_d = '0;
              if (ocol_q != OCOL_LAST) begin
                ocol_d = ocol_q + AW'(1);
              end else begin
                ocol_d = '0;
                orow_d = orow_q + AW'(1);
              end
            end
          end
          img_rd_d   = 1'b1;
          img_addr_d = img_addr_of(orow_d, ocol_d, kr_d, kc_d);
          wgt_addr_d = wgt_addr_of(kr_d, kc_d);
        end
      end
      DRAIN: begin
        if (q_en && res_idx_q == RES_LAST) begin
          state_d   = DONE;
          done_d    = 1'b1;
          res_idx_d = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q    <= IDLE;
      orow_q     <= '0;
      ocol_q     <= '0;
      kr_q       <= '0;
      kc_q       <= '0;
      res_idx_q  <= '0;
      img_rd_q   <= 1'b0;
      img_addr_q <= '0;
      wgt_addr_q <= '0;
      en_q       <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      orow_q     <= orow_d;
      ocol_q     <= ocol_d;
      kr_q       <= kr_d;
      kc_q       <= kc_d;
      res_idx_q  <= res_idx_d;
      img_rd_q   <= img_rd_d;
      img_addr_q <= img_addr_d;
      wgt_addr_q <= wgt_addr_d;
      en_q       <= en_d;
      first_q    <= first_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign img_rd     = img_rd_q;
  assign wgt_rd     = img_rd_q;
  assign img_addr   = img_addr_q;
  assign wgt_addr   = wgt_addr_q;
  assign en         = en_q;
  assign first_data = first_q;
  assign last_data  = last_q;
  assign res_idx    = res_idx_q;
  assign image_o    = en_q ? img_data : '0;
  assign weight_o   = en_q ? wgt_data : '0;

endmodule

// File: tb/tb_mac_feeder.sv
// Testbench for mac_feeder with a 4x4 map and 3x3 kernel (2x2 output).
// Includes synchronous image/weight memories and a reference MAC.

module tb_mac_feeder;

  localparam int WD = 8, IMG_W = 4, IMG_H = 4, K = 3, AW = 10;
  localparam int MAXC = 45;

  logic          clk = 1'b0;
  logic          rst_n, start, busy, done, img_rd, wgt_rd;
  logic [AW-1:0] img_addr;
  logic [3:0]    wgt_addr;
  logic [WD-1:0] img_data, wgt_data, image_o, weight_o;
  logic          en, first_data, last_data, q_en;
  logic [1:0]    res_idx;

  mac_feeder #(.WD(WD), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .img_rd(img_rd), .img_addr(img_addr), .img_data(img_data),
    .wgt_rd(wgt_rd), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
    .en(en), .first_data(first_data), .last_data(last_data),
    .image_o(image_o), .weight_o(weight_o), .q_en(q_en), .res_idx(res_idx)
  );

  always #5 clk = ~clk;

  // Memories: all ones, or img[a]=a+1 / wgt[a]=a+16 patterns.
  logic ones;
  always @(posedge clk) begin
    if (img_rd) img_data <= ones ? 8'd1 : 8'(img_addr + 10'd1);
    if (wgt_rd) wgt_data <= ones ? 8'd1 : 8'(wgt_addr + 4'd0 + 8'd16);
  end

  // Reference MAC: result strobe one cycle after last_data.
  int   acc, mq;
  logic mq_en, q_force;
  always @(posedge clk) begin
    if (!rst_n) begin
      acc <= 0; mq <= 0; mq_en <= 1'b0;
    end else begin
      mq_en <= 1'b0;
      if (en) begin
        automatic int s = (first_data ? 0 : acc) + int'(image_o) * int'(weight_o);
        acc <= s;
        if (last_data) begin
          mq    <= s;
          mq_en <= 1'b1;
        end
      end
    end
  end
  assign q_en = mq_en | q_force;

  int n_vec = 0, n_fail = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Per-cycle log of one pass; cycle 1 is the cycle after start is sampled.
  int l_rd[MAXC+1], l_addr[MAXC+1], l_wa[MAXC+1], l_en[MAXC+1];
  int l_fd[MAXC+1], l_ld[MAXC+1], l_io[MAXC+1], l_wo[MAXC+1];
  int l_busy[MAXC+1], l_done[MAXC+1], l_qen[MAXC+1], l_res[MAXC+1], l_q[MAXC+1];

  task automatic run_pass(input int s1, input int s2, input int s3);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= MAXC; c++) begin
      @(negedge clk);
      l_rd[c] = int'(img_rd);   l_addr[c] = int'(img_addr); l_wa[c] = int'(wgt_addr);
      l_en[c] = int'(en);       l_fd[c] = int'(first_data); l_ld[c] = int'(last_data);
      l_io[c] = int'(image_o);  l_wo[c] = int'(weight_o);   l_busy[c] = int'(busy);
      l_done[c] = int'(done);   l_qen[c] = int'(q_en);      l_res[c] = int'(res_idx);
      l_q[c] = mq;
      start = (c == s1 || c == s2 || c == s3);
    end
    start = 1'b0;
  endtask

  function automatic int count_of(input int which);
    int n = 0;
    for (int c = 1; c <= MAXC; c++) begin
      case (which)
        0: n += l_en[c];
        1: n += l_done[c];
        default: n += l_qen[c];
      endcase
    end
    return n;
  endfunction

  typedef struct {
    int cyc; int rd; int addr; int wa; int en; int fd; int ld; int io; int wo; int busy;
  } vec_t;
  vec_t tv[13];

  int w0_addr[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int q_cyc[4]   = '{11, 20, 29, 38};

  initial begin
    //        cyc rd addr wa en fd ld  io  wo busy
    tv[0]  = '{1,  1, 0,  0, 0, 0, 0, 0,  0,  1};
    tv[1]  = '{2,  1, 1,  1, 1, 1, 0, 1,  16, 1};
    tv[2]  = '{3,  1, 2,  2, 1, 0, 0, 2,  17, 1};
    tv[3]  = '{4,  1, 4,  3, 1, 0, 0, 3,  18, 1};
    tv[4]  = '{9,  1, 10, 8, 1, 0, 0, 10, 23, 1};
    tv[5]  = '{10, 1, 1,  0, 1, 0, 1, 11, 24, 1};
    tv[6]  = '{11, 1, 2,  1, 1, 1, 0, 2,  16, 1};
    tv[7]  = '{28, 1, 5,  0, 1, 0, 1, 15, 24, 1};
    tv[8]  = '{29, 1, 6,  1, 1, 1, 0, 6,  16, 1};
    tv[9]  = '{36, 1, 15, 8, 1, 0, 0, 15, 23, 1};
    tv[10] = '{37, 0, 0,  0, 1, 0, 1, 16, 24, 1};
    tv[11] = '{38, 0, 0,  0, 0, 0, 0, 0,  0,  1};
    tv[12] = '{40, 0, 0,  0, 0, 0, 0, 0,  0,  0};

    rst_n = 1'b0; start = 1'b0; q_force = 1'b0; ones = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy", int'(busy), 0);
    check("rst img_rd", int'(img_rd), 0);
    check("rst en", int'(en), 0);
    check("rst image_o", int'(image_o), 0);
    rst_n = 1'b1;

    // Idle with no start: no reads; q_en ignored.
    repeat (4) @(negedge clk);
    check("idle img_rd", int'(img_rd), 0);
    q_force = 1'b1;
    @(negedge clk);
    q_force = 1'b0;
    @(negedge clk);
    check("idle q_en res_idx", int'(res_idx), 0);
    check("idle busy", int'(busy), 0);

    // Pass 1: patterned memories; stray starts in FETCH, DRAIN and DONE.
    run_pass(5, 37, 39);
    foreach (tv[i]) begin
      automatic int c = tv[i].cyc;
      check($sformatf("c%0d img_rd", c), l_rd[c], tv[i].rd);
      check($sformatf("c%0d img_addr", c), l_addr[c], tv[i].addr);
      check($sformatf("c%0d wgt_addr", c), l_wa[c], tv[i].wa);
      check($sformatf("c%0d en", c), l_en[c], tv[i].en);
      check($sformatf("c%0d first", c), l_fd[c], tv[i].fd);
      check($sformatf("c%0d last", c), l_ld[c], tv[i].ld);
      check($sformatf("c%0d image_o", c), l_io[c], tv[i].io);
      check($sformatf("c%0d weight_o", c), l_wo[c], tv[i].wo);
      check($sformatf("c%0d busy", c), l_busy[c], tv[i].busy);
    end
    for (int j = 0; j < 9; j++) check($sformatf("w0 tap%0d addr", j), l_addr[1 + j], w0_addr[j]);
    check("p1 en count", count_of(0), 36);
    check("p1 en c2..37", int'(l_en[1] == 0 && l_en[2] == 1 && l_en[37] == 1), 1);
    check("p1 done count", count_of(1), 1);
    check("p1 done c39", l_done[39], 1);
    check("p1 busy c39", l_busy[39], 1);
    check("p1 idle c45", l_busy[45] + l_rd[45], 0);

    // Pass 2: all-ones memories; four results of 9.
    ones = 1'b1;
    run_pass(0, 0, 0);
    check("p2 q_en count", count_of(2), 4);
    for (int r = 0; r < 4; r++) begin
      check($sformatf("p2 q%0d strobe", r), l_qen[q_cyc[r]], 1);
      check($sformatf("p2 q%0d value", r), l_q[q_cyc[r]], 9);
      check($sformatf("p2 q%0d res_idx", r), l_res[q_cyc[r]], r);
    end
    check("p2 done c39", l_done[39], 1);
    check("p2 busy drop c40", l_busy[40], 0);

    // Reset for one cycle in the middle of window 1.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre-rst res_idx", int'(res_idx), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid-rst busy", int'(busy), 0);
    check("mid-rst img_rd", int'(img_rd) + int'(wgt_rd), 0);
    check("mid-rst addrs", int'(img_addr) + int'(wgt_addr), 0);
    check("mid-rst flags", int'(en) + int'(first_data) + int'(last_data), 0);
    check("mid-rst operands", int'(image_o) + int'(weight_o), 0);
    check("mid-rst done/res", int'(done) + int'(res_idx), 0);
    repeat (2) @(negedge clk);
    check("post-rst img_rd", int'(img_rd), 0);

    run_pass(0, 0, 0);
    check("p3 c1 img_rd", l_rd[1], 1);
    check("p3 c1 img_addr", l_addr[1], 0);
    check("p3 c2 first", l_fd[2], 1);
    check("p3 en count", count_of(0), 36);
    check("p3 q_en count", count_of(2), 4);
    check("p3 done count", count_of(1), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
